// File: rtl/tx_segment_buffer.sv
// Segment buffer: collects one segment of pixels, streams it as bytes, and keeps
// a replay copy of the last fully transmitted segment for retransmission.
//
// state       | meaning
// IDLE        | accepting pixels, waiting for start
// SEND_LIVE   | streaming the live store, copying each byte into the replay store
// SEND_REPLAY | streaming the replay store
module tx_segment_buffer #(
    parameter int NUM_CH  = 3,
    parameter int SEG_PIX = 360,
    parameter int ADDR_W  = 11
) (
    input  logic                  clk125MHz,
    input  logic                  rst,
    input  logic                  pix_valid,
    input  logic [NUM_CH*8-1:0]   pix_data,
    output logic                  pix_ready,
    input  logic                  start,
    input  logic [7:0]            txid,
    output logic                  byte_valid,
    output logic [7:0]            byte_data,
    output logic                  byte_last,
    input  logic                  byte_ready,
    output logic                  busy,
    output logic                  seg_full,
    output logic                  err
);
    localparam int SEG_BYTES = NUM_CH * SEG_PIX;
    localparam int PIX_W     = $clog2(SEG_PIX + 1);
    localparam int PIDX_W    = (SEG_PIX > 1) ? $clog2(SEG_PIX) : 1;
    localparam int BIDX_W    = (SEG_BYTES > 1) ? $clog2(SEG_BYTES) : 1;
    localparam int CH_W      = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(SEG_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SEND_LIVE, SEND_REPLAY} state_t;

    logic [NUM_CH*8-1:0] live_mem   [SEG_PIX];
    logic [7:0]          replay_mem [SEG_BYTES];

    state_t              state;
    logic [PIX_W-1:0]    pix_cnt;
    logic                replay_valid;
    logic [ADDR_W-1:0]   rd_addr;
    logic [ADDR_W-1:0]   out_addr;
    logic [PIX_W-1:0]    rd_pix;
    logic [CH_W-1:0]     rd_ch;
    logic [CH_W-1:0]     out_ch;
    logic                issued_last;
    logic                src_replay;
    logic [NUM_CH*8-1:0] live_q;
    logic [7:0]          replay_q;
    logic [7:0]          live_byte;

    logic pix_wr, xfer, adv;

    assign pix_ready = (state == IDLE) && !seg_full;
    assign busy      = (state != IDLE);
    assign pix_wr    = pix_valid && pix_ready;
    assign xfer      = byte_valid && byte_ready;
    // Fetch the next byte whenever the output register is empty or draining.
    assign adv       = busy && !issued_last && (!byte_valid || byte_ready);

    always_comb begin
        live_byte = 8'd0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (out_ch == CH_W'(c))
                live_byte = live_q[c*8 +: 8];
        end
    end

    assign byte_data = src_replay ? replay_q : live_byte;

    always_ff @(posedge clk125MHz) begin
        if (pix_wr)
            live_mem[pix_cnt[PIDX_W-1:0]] <= pix_data;
    end

    always_ff @(posedge clk125MHz) begin
        if (state == SEND_LIVE && xfer)
            replay_mem[out_addr[BIDX_W-1:0]] <= byte_data;
    end

    // RAM read registers double as the byte output register.
    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            live_q   <= '0;
            replay_q <= 8'd0;
            out_ch   <= '0;
        end else if (adv) begin
            live_q   <= live_mem[rd_pix[PIDX_W-1:0]];
            replay_q <= replay_mem[rd_addr[BIDX_W-1:0]];
            out_ch   <= rd_ch;
        end
    end

    always_ff @(posedge clk125MHz or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pix_cnt      <= '0;
            seg_full     <= 1'b0;
            replay_valid <= 1'b0;
            err          <= 1'b0;
            byte_valid   <= 1'b0;
            byte_last    <= 1'b0;
            rd_addr      <= '0;
            out_addr     <= '0;
            rd_pix       <= '0;
            rd_ch        <= '0;
            issued_last  <= 1'b0;
            src_replay   <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    if (pix_wr) begin
                        pix_cnt  <= pix_cnt + PIX_W'(1);
                        seg_full <= (pix_cnt + PIX_W'(1)) == PIX_W'(SEG_PIX);
                    end
                    if (start) begin
                        if (txid == 8'd1 && seg_full) begin
                            state        <= SEND_LIVE;
                            replay_valid <= 1'b0;
                            src_replay   <= 1'b0;
                        end else if (txid >= 8'd2 && replay_valid) begin
                            state      <= SEND_REPLAY;
                            src_replay <= 1'b1;
                        end else begin
                            err <= 1'b1;
                        end
                        rd_addr     <= '0;
                        rd_pix      <= '0;
                        rd_ch       <= '0;
                        issued_last <= 1'b0;
                    end
                end
                SEND_LIVE, SEND_REPLAY: begin
                    if (adv) begin
                        byte_valid <= 1'b1;
                        byte_last  <= (rd_addr == LAST_ADDR);
                        out_addr   <= rd_addr;
                        if (rd_addr == LAST_ADDR) begin
                            issued_last <= 1'b1;
                        end else begin
                            rd_addr <= rd_addr + ADDR_W'(1);
                            if (rd_ch == CH_W'(NUM_CH - 1)) begin
                                rd_ch  <= '0;
                                rd_pix <= rd_pix + PIX_W'(1);
                            end else begin
                                rd_ch <= rd_ch + CH_W'(1);
                            end
                        end
                    end else if (xfer) begin
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                    end
                    if (xfer && byte_last) begin
                        state      <= IDLE;
                        byte_valid <= 1'b0;
                        byte_last  <= 1'b0;
                        if (state == SEND_LIVE) begin
                            replay_valid <= 1'b1;
                            pix_cnt      <= '0;
                            seg_full     <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_tx_segment_buffer.sv
// Bench for tx_segment_buffer with NUM_CH=3, SEG_PIX=4: scenario tasks checked
// against a byte-array model of the live and replay segments.
module tb_tx_segment_buffer;
    localparam int NCH = 3;
    localparam int NPIX = 4;
    localparam int NB = NCH * NPIX;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_valid = 1'b0;
    logic [NCH*8-1:0] pix_data = '0;
    logic pix_ready;
    logic start = 1'b0;
    logic [7:0] txid = 8'd0;
    logic byte_valid, byte_last, busy, seg_full, err;
    logic [7:0] byte_data;
    logic byte_ready = 1'b0;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_live [NB];
    logic [7:0] m_replay [NB];
    logic [7:0] exp_stream [NB];
    int m_cnt = 0;

    tx_segment_buffer #(.NUM_CH(NCH), .SEG_PIX(NPIX), .ADDR_W(4)) dut (
        .clk125MHz(clk), .rst(rst), .pix_valid(pix_valid), .pix_data(pix_data),
        .pix_ready(pix_ready), .start(start), .txid(txid), .byte_valid(byte_valid),
        .byte_data(byte_data), .byte_last(byte_last), .byte_ready(byte_ready),
        .busy(busy), .seg_full(seg_full), .err(err)
    );

    always #4 clk = ~clk;

    task automatic write_pix(input logic [NCH*8-1:0] d);
        logic exp_rdy;
        @(negedge clk);
        pix_valid = 1'b1;
        pix_data = d;
        exp_rdy = (m_cnt < NPIX);
        checks++;
        if (pix_ready !== exp_rdy) begin
            errors++;
            $display("FAIL pix_ready: got %b want %b", pix_ready, exp_rdy);
        end
        if (exp_rdy) begin
            for (int c = 0; c < NCH; c++) m_live[m_cnt*NCH + c] = d[c*8 +: 8];
            m_cnt++;
        end
        @(negedge clk);
        pix_valid = 1'b0;
        checks++;
        if (seg_full !== (m_cnt == NPIX)) begin
            errors++;
            $display("FAIL seg_full after write: got %b want %b", seg_full, (m_cnt == NPIX));
        end
    endtask

    task automatic expect_reject(input logic [7:0] id, input string name);
        @(negedge clk);
        start = 1'b1;
        txid = id;
        @(negedge clk);
        start = 1'b0;
        checks++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s: err=%b busy=%b want err=1 busy=0", name, err, busy);
        end
        @(negedge clk);
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL %s pulse width: err=%b want 0", name, err);
        end
    endtask

    // mode 0: ready always high, 1: pattern 1,0,0,1, 2: random
    task automatic run_send(input logic [7:0] id, input int mode, input bit inject, input string name);
        logic [7:0] got [$];
        int got_cyc [$];
        bit got_last [$];
        bit stalled = 0;
        bit done = 0;
        logic [7:0] held = 8'd0;
        bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
        @(negedge clk);
        start = 1'b1;
        txid = id;
        byte_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k < 300 && !done; k++) begin
            case (mode)
                0: byte_ready = 1'b1;
                1: byte_ready = pat[k % 4];
                default: byte_ready = 1'($urandom_range(0, 1));
            endcase
            if (inject) begin
                start = (k == 5);
                txid = 8'd1;
            end
            if (k == 1) begin
                checks++;
                if (byte_valid !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s early: valid=%b busy=%b want 0/1", name, byte_valid, busy);
                end
            end
            if (stalled) begin
                checks++;
                if (byte_valid !== 1'b1 || byte_data !== held) begin
                    errors++;
                    $display("FAIL %s stall hold: valid=%b data=%h want 1/%h", name, byte_valid, byte_data, held);
                end
            end
            if (err !== 1'b0) begin
                errors++;
                $display("FAIL %s err during send: got %b want 0", name, err);
            end
            if (byte_valid === 1'b1 && byte_ready) begin
                got.push_back(byte_data);
                got_cyc.push_back(k);
                got_last.push_back(byte_last);
                if (byte_last === 1'b1) done = 1;
            end
            stalled = (byte_valid === 1'b1) && !byte_ready;
            held = byte_data;
            @(negedge clk);
        end
        start = 1'b0;
        byte_ready = 1'b0;
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL %s timeout: got %0d bytes want %0d", name, got.size(), NB);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s return idle: busy=%b want 0", name, busy);
        end
        checks++;
        if (got.size() != NB) begin
            errors++;
            $display("FAIL %s length: got %0d want %0d", name, got.size(), NB);
        end
        for (int i = 0; i < NB && i < got.size(); i++) begin
            checks++;
            if (got[i] !== exp_stream[i] || got_last[i] !== (i == NB - 1)) begin
                errors++;
                $display("FAIL %s byte %0d: got %h last=%b want %h last=%b", name, i, got[i], got_last[i], exp_stream[i], (i == NB - 1));
            end
            if (mode == 0) begin
                checks++;
                if (got_cyc[i] != i + 2) begin
                    errors++;
                    $display("FAIL %s timing byte %0d: cycle %0d want %0d", name, i, got_cyc[i], i + 2);
                end
            end
        end
    endtask

    task automatic live_send(input int mode, input bit inject, input string name);
        for (int i = 0; i < NB; i++) exp_stream[i] = m_live[i];
        run_send(8'd1, mode, inject, name);
        for (int i = 0; i < NB; i++) m_replay[i] = m_live[i];
        m_cnt = 0;
        checks++;
        if (seg_full !== 1'b0 || pix_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s post: seg_full=%b pix_ready=%b want 0/1", name, seg_full, pix_ready);
        end
    endtask

    task automatic replay_send(input logic [7:0] id, input int mode, input string name);
        logic sf_before;
        sf_before = (m_cnt == NPIX);
        for (int i = 0; i < NB; i++) exp_stream[i] = m_replay[i];
        run_send(id, mode, 1'b0, name);
        checks++;
        if (seg_full !== sf_before || pix_ready !== !sf_before) begin
            errors++;
            $display("FAIL %s post: seg_full=%b pix_ready=%b want %b/%b", name, seg_full, pix_ready, sf_before, !sf_before);
        end
    endtask

    task automatic test_reset();
        #3;
        checks++;
        if (byte_valid !== 0 || byte_last !== 0 || byte_data !== 8'd0 || busy !== 0 ||
            seg_full !== 0 || err !== 0 || pix_ready !== 1) begin
            errors++;
            $display("FAIL reset: valid=%b last=%b data=%h busy=%b full=%b err=%b rdy=%b want 0,0,00,0,0,0,1",
                     byte_valid, byte_last, byte_data, busy, seg_full, err, pix_ready);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (pix_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset release: rdy=%b busy=%b want 1/0", pix_ready, busy);
        end
    endtask

    task automatic test_errors();
        expect_reject(8'd0, "err_txid0");
        expect_reject(8'd3, "err_no_replay");
        write_pix(24'h030201);
        write_pix(24'h060504);
        expect_reject(8'd1, "err_not_full");
    endtask

    task automatic test_fill();
        write_pix(24'h090807);
        write_pix(24'h0C0B0A);
        write_pix(24'hAABBCC);
    endtask

    task automatic test_first_send();
        live_send(0, 1'b0, "first_send");
        checks++;
        if (m_replay[0] !== 8'h01 || m_replay[NB-1] !== 8'h0C) begin
            errors++;
            $display("FAIL model fill: got %h..%h want 01..0c", m_replay[0], m_replay[NB-1]);
        end
    endtask

    task automatic test_replay();
        replay_send(8'd5, 0, "replay");
    endtask

    task automatic test_backpressure();
        for (int p = 0; p < NPIX; p++) write_pix(24'($urandom));
        live_send(1, 1'b0, "bp_live");
        replay_send(8'($urandom_range(2, 255)), 1, "bp_replay");
    endtask

    task automatic test_random();
        for (int r = 0; r < 3; r++) begin
            for (int p = 0; p < NPIX; p++) write_pix(24'($urandom));
            replay_send(8'($urandom_range(2, 255)), 2, "rnd_old_replay");
            live_send(2, 1'b1, "rnd_live");
            replay_send(8'($urandom_range(2, 255)), 2, "rnd_replay");
        end
    endtask

    task automatic test_abort();
        int n = 0;
        for (int p = 0; p < NPIX; p++) write_pix(24'($urandom));
        @(negedge clk);
        start = 1'b1;
        txid = 8'd1;
        byte_ready = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 50 && n < 6; k++) begin
            if (byte_valid === 1'b1) n++;
            if (n < 6) @(negedge clk);
        end
        checks++;
        if (n != 6) begin
            errors++;
            $display("FAIL abort reach byte 6: got %0d want 6", n);
        end
        #1 rst = 1'b1;
        #1;
        checks++;
        if (byte_valid !== 0 || byte_last !== 0 || byte_data !== 8'd0 || busy !== 0 ||
            seg_full !== 0 || err !== 0 || pix_ready !== 1) begin
            errors++;
            $display("FAIL abort reset: valid=%b last=%b data=%h busy=%b full=%b err=%b rdy=%b want 0,0,00,0,0,0,1",
                     byte_valid, byte_last, byte_data, busy, seg_full, err, pix_ready);
        end
        byte_ready = 1'b0;
        m_cnt = 0;
        @(negedge clk);
        rst = 1'b0;
        expect_reject(8'd2, "abort_no_replay");
    endtask

    initial begin
        test_reset();
        test_errors();
        test_fill();
        test_first_send();
        test_replay();
        test_backpressure();
        test_random();
        test_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/tx_segment_buffer.md
TX_SEGMENT_BUFFER -- requirements
Module: tx_segment_buffer

Interface
REQ-001 Parameter NUM_CH, default 3: colour channels per pixel, 8 bits each, range 1..4.
REQ-002 Parameter SEG_PIX, default 360: pixels per segment; one segment is NUM_CH*SEG_PIX bytes (1080 at defaults).
REQ-003 Parameter ADDR_W, default 11: byte address width; SHALL satisfy 2^ADDR_W >= NUM_CH*SEG_PIX.
REQ-004 clk125MHz  in  1  sole clock; all logic on its rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 pix_valid  in  1  pixel write strobe.
REQ-007 pix_data  in  NUM_CH*8  pixel; channel c occupies bits [8c+7:8c].
REQ-008 pix_ready  out  1  live store accepts a pixel this cycle.
REQ-009 start  in  1  single-cycle request to transmit one segment.
REQ-010 txid  in  8  sampled with start: 1 = first transmission, 2..255 = replay, 0 = invalid.
REQ-011 byte_valid  out  1  byte_data valid.
REQ-012 byte_data  out  8  segment byte stream.
REQ-013 byte_last  out  1  marks the final byte of the segment.
REQ-014 byte_ready  in  1  downstream accepts; a transfer occurs when byte_valid && byte_ready.
REQ-015 busy  out  1  high in SEND_LIVE or SEND_REPLAY.
REQ-016 seg_full  out  1  live store holds SEG_PIX pixels.
REQ-017 err  out  1  one-cycle pulse on a rejected start.

Function
REQ-018 Storage: the live store and the replay store, each NUM_CH*SEG_PIX bytes, are synchronous-read single-clock RAMs with 1-cycle read latency.
REQ-019 States: IDLE, SEND_LIVE, SEND_REPLAY; reset state IDLE.
REQ-020 pix_ready = (state==IDLE) && !seg_full.
REQ-021 On pix_valid && pix_ready, the block SHALL write NUM_CH bytes at byte addresses pix_cnt*NUM_CH+c and increment pix_cnt.
REQ-022 seg_full SHALL assert on the cycle after pix_cnt reaches SEG_PIX.
REQ-023 pix_valid while pix_ready is low SHALL be dropped without error.
REQ-024 IDLE to SEND_LIVE: start && txid==1 && seg_full.
REQ-025 IDLE to SEND_REPLAY: start && txid>=2 && replay_valid.
REQ-026 In IDLE, start with txid==0, with txid==1 && !seg_full, or with txid>=2 && !replay_valid SHALL pulse err one cycle after start and remain in IDLE.
REQ-027 start while busy SHALL be ignored, with no err.
REQ-028 Byte order: pixel 0 to SEG_PIX-1; within each pixel, channel 0 first, then ascending channel.
REQ-029 The first byte_valid SHALL assert 2 cycles after the start cycle.
REQ-030 Under continuous byte_ready, one byte SHALL transfer per cycle.
REQ-031 byte_data SHALL hold stable while byte_valid && !byte_ready, and read addresses SHALL stall during that condition.
REQ-032 In SEND_LIVE, each transferred byte SHALL also be written to the replay store at the same address.
REQ-033 byte_last SHALL be high only with the byte at address NUM_CH*SEG_PIX-1.
REQ-034 On the byte_last transfer in SEND_LIVE, on the next cycle: replay_valid=1, pix_cnt=0, seg_full=0, state=IDLE.
REQ-035 On the byte_last transfer in SEND_REPLAY, on the next cycle: state=IDLE; pix_cnt, seg_full and replay_valid are unchanged.
REQ-036 Address counters SHALL not exceed NUM_CH*SEG_PIX-1; no wrap-around within a segment.
REQ-037 A new SEND_LIVE SHALL overwrite the replay store; a replay of the previous segment SHALL be impossible once the new SEND_LIVE begins.

Reset
REQ-038 rst SHALL asynchronously force: state=IDLE, pix_cnt=0, replay_valid=0, byte_valid=0, byte_last=0, byte_data=0, busy=0, seg_full=0, err=0.
REQ-039 pix_ready SHALL be 1 while in reset-idle.
REQ-040 RAM contents are not cleared by rst.
REQ-041 rst mid-send SHALL abort the segment, and replay_valid SHALL read 0 after release.

Verification (NUM_CH=3, SEG_PIX=4)
REQ-042 Fill: write pixels 0x030201, 0x060504, 0x090807, 0x0C0B0A -> seg_full=1 and pix_ready=0 from the next cycle; a 5th pixel is dropped.
REQ-043 First send: start, txid=1, byte_ready held 1 -> bytes 01..0C on 12 consecutive cycles starting at cycle+2, byte_last on 0C, then seg_full=0.
REQ-044 Replay: start, txid=5 -> identical 12-byte stream; pix_cnt unchanged.
REQ-045 Backpressure: byte_ready toggled 1,0,0,1 repeatedly -> no byte lost or duplicated; byte_data stable while stalled.
REQ-046 Errors: start txid=0; start txid=3 after reset; start txid=1 with 2 pixels -> err pulse each, state stays IDLE.
REQ-047 Abort: rst asserted at byte 6 of SEND_LIVE -> outputs at reset values immediately; a following start txid=2 -> err.
